// File: rtl/mem_access_unit_pkg.sv
// Shared load/store definitions: access sizes, LSU states and size helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Encoding 3 is not a real size; it behaves exactly like a word access.
  function automatic mem_size_e norm_size(input logic [1:0] size);
    return (size == 2'd3) ? MEM_W : mem_size_e'(size);
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    case (size)
      MEM_H:   return off[0];
      MEM_W:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_load_align.sv
// Extracts the addressed byte/half from a raw read word and sign/zero-extends it.
module lsu_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        unsign,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to access size.
  always_comb begin
    byte_sel = rdata[8*off +: 8];
    half_sel = rdata[16*off[1] +: 16];
    case (size)
      MEM_B:   result = {{24{byte_sel[7] & ~unsign}}, byte_sel};
      MEM_H:   result = {{16{half_sel[15] & ~unsign}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding req/addr_ok/data_ok transaction on the data SRAM bus.
//
// state | meaning
// IDLE  | ready for a new memory instruction
// REQ   | request driven, waiting for addr_ok
// WAIT  | address taken, waiting for data_ok
// RESP  | one-cycle completion pulse (result or address error)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size_mem,
  input  logic              is_unsign_load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              out_valid,
  output logic [31:0]       out_rdata,
  output logic              out_ale
);

  lsu_state_e        state_q, state_d;
  mem_size_e         size_in, size_q;
  logic              accept, misaligned;
  logic              wr_q, unsign_q, ale_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        strb_in, wstrb_q;
  logic [31:0]       wdata_in, wdata_q, rdata_q, load_result;

  assign size_in    = norm_size(size_mem);
  assign accept     = in_valid & (mem_read | mem_write);
  assign misaligned = is_misaligned(size_in, addr[1:0]);

  // Store formatting: byte enables and lane-replicated data for the incoming access.
  always_comb begin
    case (size_in)
      MEM_B: begin
        strb_in  = 4'b0001 << addr[1:0];
        wdata_in = {4{wdata[7:0]}};
      end
      MEM_H: begin
        strb_in  = 4'b0011 << {addr[1], 1'b0};
        wdata_in = {2{wdata[15:0]}};
      end
      default: begin
        strb_in  = 4'b1111;
        wdata_in = wdata;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .rdata  (data_sram_rdata),
    .off    (addr_q[1:0]),
    .size   (size_q),
    .unsign (unsign_q),
    .result (load_result)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; misaligned accesses skip the bus entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = misaligned ? RESP : REQ;
      REQ:  if (data_sram_addr_ok) state_d = WAIT;
      WAIT: if (data_sram_data_ok) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction registers: captured on accept, result captured on data_ok.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      size_q   <= MEM_B;
      wr_q     <= 1'b0;
      unsign_q <= 1'b0;
      wstrb_q  <= 4'b0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      ale_q    <= 1'b0;
    end else if (state_q == IDLE && accept) begin
      ale_q   <= misaligned;
      rdata_q <= 32'b0;
      if (!misaligned) begin
        addr_q   <= addr;
        size_q   <= size_in;
        wr_q     <= mem_write;
        unsign_q <= is_unsign_load;
        wstrb_q  <= mem_write ? strb_in : 4'b0;
        wdata_q  <= mem_write ? wdata_in : 32'b0;
      end
    end else if (state_q == WAIT && data_sram_data_ok) begin
      rdata_q <= wr_q ? 32'b0 : load_result;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign data_sram_req   = (state_q == REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;
  assign out_valid       = (state_q == RESP);
  assign out_ale         = out_valid & ale_q;
  assign out_rdata       = out_valid ? rdata_q : 32'b0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit that consumes the decoder's memory controls (memRead, memWriteEn, size_mem, is_unsign_load) together with the ALU address and the store data.
- Drives the data-side SRAM-like bus: req/addr_ok then data_ok, one outstanding transaction.
- Returns sign- or zero-extended load data, or an address-error flag, to the writeback path.
- Holds the pipeline through in_ready while a transaction is in flight.

Parameters:
- ADDR_W, 32, address width. Only 32 is supported; data is fixed at 32 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX stage presents an instruction
- in_ready  out  1  unit idle; the request is accepted when in_valid & in_ready
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- size_mem  in  2  0 = byte, 1 = half, 2 = word, 3 is treated as word
- is_unsign_load  in  1  zero-extend the load result
- addr  in  ADDR_W  effective address
- wdata  in  32  store data (rd value)
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  1 = write
- data_sram_size  out  2  equals the latched size_mem (3 is sent as 2)
- data_sram_addr  out  ADDR_W  latched address
- data_sram_wstrb  out  4  byte enables (0 for reads)
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_addr_ok  in  1  bus accepted the request
- data_sram_data_ok  in  1  read data valid / write complete
- data_sram_rdata  in  32  raw read word
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  32  extended load result; 0 for stores and errors
- out_ale  out  1  misaligned address (valid with out_valid)

Behaviour:
- Reset state:
  - state = IDLE.
  - All outputs 0, except in_ready = 1.
  - Bus address, wdata and wstrb registers = 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - in_ready = 1.
  - Accept occurs on in_valid & (mem_read | mem_write). If in_valid arrives with neither flag set, it is ignored and no pulse is produced.
  - If mem_read and mem_write are both set, the access is treated as a write.
- Alignment check (in IDLE):
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
  - A misaligned accept goes to RESP with out_ale = 1. No bus activity occurs.
  - An aligned accept latches addr, size, wr, unsign and the formatted wdata/wstrb, then goes to REQ.
- REQ:
  - data_sram_req = 1 (registered; first asserted the cycle after accept).
  - All bus outputs are held stable until addr_ok.
  - On addr_ok: req drops the same edge, go to WAIT.
- WAIT:
  - data_sram_data_ok is sampled only in this state; the bus never returns data_ok earlier than the cycle after addr_ok.
  - On data_ok: latch the formatted load result (stores latch 0), go to RESP.
- RESP:
  - out_valid = 1 for exactly one cycle, then go to IDLE.
  - in_ready is 0 in REQ, WAIT and RESP.
- Minimum latency, with addr_ok in the first REQ cycle and data_ok in the next:
  - accept at cycle 0
  - req at cycle 1
  - data_ok at cycle 2
  - out_valid at cycle 3
- Write strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load formatting:
  - byte = rdata[8*addr[1:0] +: 8]
  - half = rdata[16*addr[1] +: 16]
  - The selected field is sign-extended, or zero-extended when unsign = 1. Word loads pass through unchanged.
- Stalls: an addr_ok stall of any length keeps state REQ with req high. A data_ok stall of any length keeps state WAIT.
- Reset mid-transaction:
  - Immediately returns to IDLE with req low; no out_valid is produced.
  - A late data_ok arriving in IDLE is ignored.

Decomposition:
- Shared cpuDefine package gains:
  - MemSize enum: MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2.
  - LsuState enum: IDLE, REQ, WAIT, RESP.
- One combinational sub-module, lsu_load_align: inputs raw word, addr[1:0], size, unsign; output the 32-bit extended result.
- Store formatting stays inline.

Test Plan:
- Aligned word store: addr = 0x1C00_0104, wdata = 0xDEAD_BEEF, addr_ok and data_ok each delayed 2 cycles.
  - req stays high 3 cycles with wr = 1, wstrb = 4'hF, size = 2.
  - One out_valid pulse, out_rdata = 0.
- Byte stores at addr offsets 0..3, wdata = 0x0000_00A5.
  - wstrb = 1, 2, 4, 8 in turn; wdata = 0xA5A5_A5A5 every time.
- Load byte at offset 3, rdata = 0x80FF_0000.
  - Signed: out_rdata = 0xFFFF_FF80.
  - is_unsign_load = 1: out_rdata = 0x0000_0080.
- Load half at offset 2, rdata = 0x8001_1234.
  - Signed: out_rdata = 0xFFFF_8001.
  - Unsigned: 0x0000_8001.
- Misaligned accesses: word at addr = 0x...02 and half at addr = 0x...01.
  - No data_sram_req.
  - out_valid with out_ale = 1 one cycle after accept; in_ready back to 1 the cycle after that.
- Reset during WAIT, followed by data_ok two cycles later.
  - State is IDLE, req = 0, no out_valid.
  - The next load completes normally.
